// File: rtl/pwm_pkg.sv
// pwm_pkg: definitions shared by the PWM ramp controller and its step timer.
//   PWM_WIDTH      - default duty/period resolution
//   PWM_INTERVAL_W - default width of the step-interval counter
//   pwm_state_t    - ramp controller state encoding
package pwm_pkg;

    localparam int PWM_WIDTH      = 8;
    localparam int PWM_INTERVAL_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RAMP     = 2'd1,
        ST_HOLD     = 2'd2,
        ST_SHUTDOWN = 2'd3
    } pwm_state_t;

endpackage

// File: rtl/pwm_step_timer.sv
// pwm_step_timer: interval counter that paces duty steps.
//   clk, rst_n - system clock, asynchronous active-low reset
//   clear      - restart the count from 0 (wins over run)
//   run        - count one cycle
//   interval   - cycles between ticks, minus 1
//   tick       - high in the cycle where the count equals interval while running;
//                the count wraps to 0 on that cycle
module pwm_step_timer #(
    parameter int INTERVAL_W = pwm_pkg::PWM_INTERVAL_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  run,
    input  logic [INTERVAL_W-1:0] interval,
    output logic                  tick
);

    logic [INTERVAL_W-1:0] count;

    assign tick = run && (count == interval);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else if (run) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pwm_ramp_controller.sv
// pwm_ramp_controller: ramps the duty of a pwm_generator toward a commanded
// target in fixed steps at a fixed cycle interval, and ramps to 0 on stop.
//   clk, rst_n       - system clock, asynchronous active-low reset
//   cmd_valid/ready  - command handshake (ready is combinational)
//   cmd_target       - requested final duty (clamped to cfg_period)
//   cmd_step         - duty change per step (0 behaves as 1)
//   cmd_interval     - cycles between steps, minus 1
//   cfg_period       - PWM period, taken at command accept
//   stop             - ramp to 0, then disable
//   pwm_enable/duty/period - straight to pwm_generator
//   busy             - ramping or shutting down
//   done             - one-cycle pulse when a ramp reaches its target
module pwm_ramp_controller
    import pwm_pkg::*;
#(
    parameter int WIDTH      = PWM_WIDTH,
    parameter int INTERVAL_W = PWM_INTERVAL_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [WIDTH-1:0]      cmd_target,
    input  logic [WIDTH-1:0]      cmd_step,
    input  logic [INTERVAL_W-1:0] cmd_interval,
    input  logic [WIDTH-1:0]      cfg_period,
    input  logic                  stop,
    output logic                  pwm_enable,
    output logic [WIDTH-1:0]      pwm_duty,
    output logic [WIDTH-1:0]      pwm_period,
    output logic                  busy,
    output logic                  done
);

    pwm_state_t            state, state_nxt;
    logic [WIDTH-1:0]      tgt_q, tgt_nxt;
    logic [WIDTH-1:0]      step_q, step_nxt;
    logic [INTERVAL_W-1:0] iv_q, iv_nxt;
    logic [WIDTH-1:0]      duty_nxt, period_nxt;
    logic                  en_nxt, done_nxt, busy_nxt;

    logic                  accept, stop_take, run, tick;
    logic [WIDTH-1:0]      tgt_clamp, stepped;
    logic [WIDTH:0]        sum_up, tgt_plus;

    assign cmd_ready = ((state == ST_IDLE) || (state == ST_HOLD)) && !stop;
    assign accept    = cmd_valid && cmd_ready;
    assign stop_take = stop && ((state == ST_RAMP) || (state == ST_HOLD));
    assign run       = (state == ST_RAMP) || (state == ST_SHUTDOWN);
    assign tgt_clamp = (cmd_target > cfg_period) ? cfg_period : cmd_target;

    pwm_step_timer #(.INTERVAL_W(INTERVAL_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept || stop_take),
        .run      (run),
        .interval (iv_q),
        .tick     (tick)
    );

    // One step toward the target, evaluated one bit wider so duty+step and
    // target+step cannot wrap; landing within one step snaps to the target.
    assign sum_up   = {1'b0, pwm_duty} + {1'b0, step_q};
    assign tgt_plus = {1'b0, tgt_q} + {1'b0, step_q};

    always_comb begin
        stepped = tgt_q;
        if (pwm_duty < tgt_q) begin
            if (sum_up < {1'b0, tgt_q}) stepped = sum_up[WIDTH-1:0];
        end else begin
            if (tgt_plus < {1'b0, pwm_duty}) stepped = pwm_duty - step_q;
        end
    end

    always_comb begin
        state_nxt  = state;
        tgt_nxt    = tgt_q;
        step_nxt   = step_q;
        iv_nxt     = iv_q;
        duty_nxt   = pwm_duty;
        period_nxt = pwm_period;
        en_nxt     = pwm_enable;
        done_nxt   = 1'b0;

        if (stop_take) begin
            // Stop overrides any step due this cycle; step/interval are kept.
            tgt_nxt = '0;
            if (pwm_duty == '0) begin
                state_nxt = ST_IDLE;
                en_nxt    = 1'b0;
            end else begin
                state_nxt = ST_SHUTDOWN;
            end
        end else begin
            case (state)
                ST_IDLE, ST_HOLD: begin
                    if (accept) begin
                        tgt_nxt    = tgt_clamp;
                        step_nxt   = (cmd_step == '0) ? WIDTH'(1) : cmd_step;
                        iv_nxt     = cmd_interval;
                        period_nxt = cfg_period;
                        en_nxt     = 1'b1;
                        if (tgt_clamp == pwm_duty) begin
                            state_nxt = ST_HOLD;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = ST_RAMP;
                        end
                    end
                end
                ST_RAMP: begin
                    if (tick) begin
                        duty_nxt = stepped;
                        if (stepped == tgt_q) begin
                            state_nxt = ST_HOLD;
                            done_nxt  = 1'b1;
                        end
                    end
                end
                ST_SHUTDOWN: begin
                    if (tick) begin
                        duty_nxt = stepped;
                        if (stepped == '0) begin
                            state_nxt = ST_IDLE;
                            en_nxt    = 1'b0;
                        end
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        busy_nxt = (state_nxt == ST_RAMP) || (state_nxt == ST_SHUTDOWN);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            tgt_q      <= '0;
            step_q     <= '0;
            iv_q       <= '0;
            pwm_duty   <= '0;
            pwm_period <= '1;
            pwm_enable <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            tgt_q      <= tgt_nxt;
            step_q     <= step_nxt;
            iv_q       <= iv_nxt;
            pwm_duty   <= duty_nxt;
            pwm_period <= period_nxt;
            pwm_enable <= en_nxt;
            done       <= done_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule
